// File: rtl/dpram_port_arbiter_pkg.sv
// dpram_arb_pkg: shared types and helpers for the dual-port RAM port arbiter (state enum, index width, one-hot to index)
package dpram_arb_pkg;
  typedef enum logic {RUN = 1'b0, SWEEP = 1'b1} arb_state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int oh2idx(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// dpram_rr_pick: combinational rotating-priority picker; in valid[N_REQ], last; out grant one-hot, idx, any
module dpram_rr_pick
  import dpram_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             any
);
  // Walk from farthest to nearest so the requester right after last wins.
  always_comb begin
    grant = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (valid[IW'((int'(last) + k) % N_REQ)]) grant = N_REQ'(1) << ((int'(last) + k) % N_REQ);
  end
  assign idx = IW'(oh2idx(32'(grant)));
  assign any = |valid;
endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin share of one RAM port among N_REQ requesters with tagged 1-cycle read responses.
//   Ports: clk, rst (async high); req_valid/req_ready/req_we/req_addr/req_wdata per requester;
//   rsp_valid (one-hot tag), rsp_rdata; clear_req, busy; mem_en/mem_we/mem_addr/mem_din/mem_dout to RAM.
//   Define DPRAM_ARB_CLEAR_EN to enable the post-reset / on-demand RAM clear sweep.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int                    N_REQ         = 4,
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_valid,
  output logic [N_REQ-1:0]                 req_ready,
  input  logic [N_REQ-1:0]                 req_we,
  input  logic [N_REQ*ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]      req_wdata,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  input  logic                             clear_req,
  output logic                             busy,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [ADDRESS_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]            mem_din,
  input  logic [DATA_WIDTH-1:0]            mem_dout
);
  localparam int IW = idx_w(N_REQ);
  arb_state_e               state;
  logic [ADDRESS_WIDTH-1:0] sweep_addr;
  logic                     clear_eff;
  logic [IW-1:0]            rr_last, g_idx;
  logic [N_REQ-1:0]         g_oh, tag;
  logic                     any, run, sweeping, grant_ok;
`ifdef DPRAM_ARB_CLEAR_EN
  assign clear_eff = clear_req;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= SWEEP;
      sweep_addr <= '0;
      busy       <= 1'b1;
    end else if (state == SWEEP) begin
      sweep_addr <= sweep_addr + 1'b1;
      if (&sweep_addr) begin
        state <= RUN;
        busy  <= 1'b0;
      end
    end else if (clear_req) begin
      state      <= SWEEP;
      sweep_addr <= '0;
      busy       <= 1'b1;
    end
`else
  logic unused_clear;
  assign unused_clear = clear_req;
  assign clear_eff    = 1'b0;
  assign state        = RUN;
  assign sweep_addr   = '0;
  assign busy         = 1'b0;
`endif
  dpram_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .valid(req_valid),
    .last (rr_last),
    .grant(g_oh),
    .idx  (g_idx),
    .any  (any)
  );
  // Reset also masks the combinational outputs so the port is quiet while rst is held.
  assign run       = state == RUN && !clear_eff && !rst;
  assign sweeping  = state == SWEEP && !rst;
  assign grant_ok  = run && any;
  assign req_ready = run ? g_oh : '0;
  assign mem_en    = sweeping || grant_ok;
  assign mem_we    = sweeping || (grant_ok && req_we[g_idx]);
  assign mem_addr  = sweeping ? sweep_addr : req_addr[int'(g_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign mem_din   = sweeping ? INIT_VALUE : req_wdata[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign rsp_valid = tag;
  assign rsp_rdata = mem_dout;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rr_last <= IW'(N_REQ - 1);
      tag     <= '0;
    end else begin
      tag <= (grant_ok && !req_we[g_idx]) ? g_oh : '0;
      if (grant_ok) rr_last <= g_idx;
    end
endmodule
